// File: rtl/rob_retire_queue_pkg.sv
// rob_retire_queue_pkg: shared widths and entry/retire record types for the reorder buffer
package rob_retire_queue_pkg;
    localparam int ISSUE_WIDTH_MAX = 2;
    localparam int ROB_MAX_RETIRE = 2;
    localparam int ROB_DEPTH = 32;
    localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);
    localparam int SRC_LEN = 5;
    localparam int DATA_LEN = 32;
    typedef struct packed {
        logic v;
        logic rfWrite;
        logic [SRC_LEN-1:0] rd;
        logic [DATA_LEN-1:0] data;
    } info_ret_t;
    typedef struct packed {
        logic valid;
        logic done;
        logic rfWrite;
        logic [SRC_LEN-1:0] rd;
        logic [DATA_LEN-1:0] data;
    } rob_entry_t;
endpackage

// File: rtl/rob_retire_queue_retire_select.sv
// rob_retire_select: prefix-AND of per-lane ready bits giving retire mask and count
module rob_retire_select #(
    parameter int W = 2,
    localparam int CNTW = $clog2(W + 1)
) (
    input  logic [W-1:0]    ready,
    output logic [W-1:0]    mask,
    output logic [CNTW-1:0] cnt
);
    always_comb begin
        mask = '0;
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i == 0) ? ready[i] : (mask[i-1] & ready[i]);
            cnt = cnt + CNTW'(mask[i]);
        end
    end
endmodule

// File: rtl/rob_retire_queue.sv
// rob_retire_queue: in-order reorder buffer retiring oldest completed entries to the register file
module rob_retire_queue
    import rob_retire_queue_pkg::*;
#(
    parameter int ROB_DEPTH = rob_retire_queue_pkg::ROB_DEPTH,
    parameter int ALLOC_WIDTH = ISSUE_WIDTH_MAX,
    parameter int WB_WIDTH = 2,
    parameter int RET_WIDTH = ROB_MAX_RETIRE,
    localparam int IW = $clog2(ROB_DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [ALLOC_WIDTH-1:0]              alloc_v,
    input  logic [ALLOC_WIDTH-1:0][SRC_LEN-1:0] alloc_rd,
    input  logic [ALLOC_WIDTH-1:0]              alloc_rfWrite,
    output logic                                alloc_rdy,
    output logic [ALLOC_WIDTH-1:0][IW-1:0]      alloc_robid,
    input  logic [WB_WIDTH-1:0]                 wb_v,
    input  logic [WB_WIDTH-1:0][IW-1:0]         wb_robid,
    input  logic [WB_WIDTH-1:0][DATA_LEN-1:0]   wb_data,
    output info_ret_t [RET_WIDTH-1:0]           info_ret,
    output logic                                empty
);
    localparam int CW = IW + 1;
    localparam int RCW = $clog2(RET_WIDTH + 1);
    rob_entry_t rob [ROB_DEPTH];
    logic [CW-1:0] head, tail, count, n_alloc;
    logic [RET_WIDTH-1:0] ready, mask;
    logic [RCW-1:0] n_ret;
    logic [IW-1:0] ret_idx [RET_WIDTH];

    // alloc_rdy looks only at current occupancy, so allocation can never land on a retiring slot
    always_comb begin
        alloc_rdy = count <= CW'(ROB_DEPTH - ALLOC_WIDTH);
        empty = count == '0;
        n_alloc = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_robid[k] = tail[IW-1:0] + IW'(k);
            n_alloc = n_alloc + CW'(alloc_v[k] & alloc_rdy);
        end
        for (int r = 0; r < RET_WIDTH; r++) begin
            ret_idx[r] = head[IW-1:0] + IW'(r);
            ready[r] = rob[ret_idx[r]].valid & rob[ret_idx[r]].done;
        end
    end

    rob_retire_select #(.W(RET_WIDTH)) u_sel (.ready(ready), .mask(mask), .cnt(n_ret));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
            for (int r = 0; r < RET_WIDTH; r++) info_ret[r] <= '0;
        end else begin
            for (int w = 0; w < WB_WIDTH; w++)
                if (wb_v[w] && rob[wb_robid[w]].valid) begin
                    rob[wb_robid[w]].done <= 1'b1;
                    rob[wb_robid[w]].data <= wb_data[w];
                end
            for (int r = 0; r < RET_WIDTH; r++) begin
                info_ret[r] <= '{v: mask[r], rfWrite: rob[ret_idx[r]].rfWrite,
                                 rd: rob[ret_idx[r]].rd, data: rob[ret_idx[r]].data};
                if (mask[r]) rob[ret_idx[r]].valid <= 1'b0;
            end
            for (int k = 0; k < ALLOC_WIDTH; k++)
                if (alloc_v[k] && alloc_rdy)
                    rob[alloc_robid[k]] <= '{valid: 1'b1, done: 1'b0, rfWrite: alloc_rfWrite[k],
                                             rd: alloc_rd[k], data: '0};
            head <= head + CW'(n_ret);
            tail <= tail + n_alloc;
            count <= count + n_alloc - CW'(n_ret);
        end
    end
endmodule

// File: tb/tb_rob_retire_queue.sv
// tb_rob_retire_queue: directed scenario tests for rob_retire_queue with hand-computed expectations
module tb_rob_retire_queue;
    import rob_retire_queue_pkg::*;
    logic clk = 1'b0;
    logic rst, flush;
    logic [1:0] alloc_v, alloc_rfWrite;
    logic [1:0][4:0] alloc_rd;
    logic alloc_rdy;
    logic [1:0][4:0] alloc_robid;
    logic [1:0] wb_v;
    logic [1:0][4:0] wb_robid;
    logic [1:0][31:0] wb_data;
    info_ret_t [1:0] info_ret;
    logic empty;
    int errors = 0;
    int checks = 0;
    info_ret_t exp;

    rob_retire_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .alloc_v(alloc_v), .alloc_rd(alloc_rd),
        .alloc_rfWrite(alloc_rfWrite), .alloc_rdy(alloc_rdy), .alloc_robid(alloc_robid),
        .wb_v(wb_v), .wb_robid(wb_robid), .wb_data(wb_data), .info_ret(info_ret), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic info_ret_t mk(input logic w, input logic [4:0] rd, input logic [31:0] d);
        return '{v: 1'b1, rfWrite: w, rd: rd, data: d};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        rst = 1'b0; flush = 1'b0; alloc_v = '0; alloc_rfWrite = '0; alloc_rd = '0;
        wb_v = '0; wb_robid = '0; wb_data = '0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc2(input logic [4:0] rd0, input logic [4:0] rd1, input logic [1:0] wr);
        alloc_v = 2'b11; alloc_rd[0] = rd0; alloc_rd[1] = rd1; alloc_rfWrite = wr;
        tick();
        alloc_v = '0;
    endtask

    task automatic wb2(input logic [1:0] v, input logic [4:0] id0, input logic [4:0] id1,
                       input logic [31:0] d0, input logic [31:0] d1);
        wb_v = v; wb_robid[0] = id0; wb_robid[1] = id1; wb_data[0] = d0; wb_data[1] = d1;
        tick();
        wb_v = '0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy got=%b want=1", alloc_rdy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL reset_v0 got=%b want=0", info_ret[0].v); end
        checks++; if (info_ret[1].v !== 1'b0) begin errors++; $display("FAIL reset_v1 got=%b want=0", info_ret[1].v); end
        checks++; if (alloc_robid[0] !== 5'd0) begin errors++; $display("FAIL reset_robid0 got=%0d want=0", alloc_robid[0]); end
        checks++; if (alloc_robid[1] !== 5'd1) begin errors++; $display("FAIL reset_robid1 got=%0d want=1", alloc_robid[1]); end
    endtask

    task automatic test_basic_retire;
        do_reset();
        alloc2(5'd5, 5'd6, 2'b11);
        wb2(2'b01, 5'd1, 5'd0, 32'hBB, 32'h0);
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL basic_no_early got=%b want=0", info_ret[0].v); end
        wb2(2'b01, 5'd0, 5'd0, 32'hAA, 32'h0);
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL basic_latency got=%b want=0", info_ret[0].v); end
        tick();
        exp = mk(1'b1, 5'd5, 32'hAA);
        checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL basic_lane0 got=%h want=%h", info_ret[0], exp); end
        exp = mk(1'b1, 5'd6, 32'hBB);
        checks++; if (info_ret[1] !== exp) begin errors++; $display("FAIL basic_lane1 got=%h want=%h", info_ret[1], exp); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b want=1", empty); end
        tick();
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL basic_after got=%b want=0", info_ret[0].v); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 15; i++) alloc2(5'(2*i), 5'(2*i+1), 2'b10);
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy30 got=%b want=1", alloc_rdy); end
        alloc_v = 2'b01; alloc_rd[0] = 5'd30; alloc_rfWrite = 2'b00;
        tick();
        alloc_v = '0;
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy31 got=%b want=0", alloc_rdy); end
        checks++; if (alloc_robid[0] !== 5'd31) begin errors++; $display("FAIL full_tail31 got=%0d want=31", alloc_robid[0]); end
        alloc_v = 2'b11; alloc_rd[0] = 5'd1; alloc_rd[1] = 5'd2;
        tick();
        alloc_v = '0;
        checks++; if (alloc_robid[0] !== 5'd31) begin errors++; $display("FAIL full_dropped got=%0d want=31", alloc_robid[0]); end
        for (int i = 15; i >= 1; i--) wb2(2'b11, 5'(2*i), 5'(2*i-1), 32'h1000 + 32'(2*i), 32'h1000 + 32'(2*i-1));
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL full_head_blocks got=%b want=0", info_ret[0].v); end
        wb2(2'b01, 5'd0, 5'd0, 32'h1000, 32'h0);
        for (int c = 0; c < 16; c++) begin
            tick();
            exp = mk(1'b0, 5'(2*c), 32'h1000 + 32'(2*c));
            checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL drain_lane0 c=%0d got=%h want=%h", c, info_ret[0], exp); end
            exp = mk(1'b1, 5'(2*c+1), 32'h1000 + 32'(2*c+1));
            if (c < 15) begin
                checks++; if (info_ret[1] !== exp) begin errors++; $display("FAIL drain_lane1 c=%0d got=%h want=%h", c, info_ret[1], exp); end
            end else begin
                checks++; if (info_ret[1].v !== 1'b0) begin errors++; $display("FAIL drain_last_v1 got=%b want=0", info_ret[1].v); end
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b want=1", empty); end
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after got=%b want=1", alloc_rdy); end
        checks++; if (alloc_robid[1] !== 5'd0) begin errors++; $display("FAIL full_wrap got=%0d want=0", alloc_robid[1]); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 5; i++) alloc2(5'(2*i+10), 5'(2*i+11), 2'b11);
        wb2(2'b11, 5'd0, 5'd1, 32'hA0, 32'hA1);
        checks++; if (alloc_robid[0] !== 5'd10) begin errors++; $display("FAIL b2b_tail got=%0d want=10", alloc_robid[0]); end
        alloc_v = 2'b11; alloc_rd[0] = 5'd20; alloc_rd[1] = 5'd21; alloc_rfWrite = 2'b11;
        wb2(2'b11, 5'd2, 5'd3, 32'hC2, 32'hC3);
        alloc_v = '0;
        exp = mk(1'b1, 5'd10, 32'hA0);
        checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL b2b_ret0 got=%h want=%h", info_ret[0], exp); end
        exp = mk(1'b1, 5'd11, 32'hA1);
        checks++; if (info_ret[1] !== exp) begin errors++; $display("FAIL b2b_ret1 got=%h want=%h", info_ret[1], exp); end
        checks++; if (alloc_robid[0] !== 5'd12) begin errors++; $display("FAIL b2b_tail2 got=%0d want=12", alloc_robid[0]); end
        tick();
        exp = mk(1'b1, 5'd12, 32'hC2);
        checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL b2b_ret2 got=%h want=%h", info_ret[0], exp); end
        exp = mk(1'b1, 5'd13, 32'hC3);
        checks++; if (info_ret[1] !== exp) begin errors++; $display("FAIL b2b_ret3 got=%h want=%h", info_ret[1], exp); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL b2b_not_empty got=%b want=0", empty); end
    endtask

    task automatic test_wb_invalid;
        do_reset();
        wb2(2'b01, 5'd7, 5'd0, 32'hDEAD, 32'h0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL inv_empty got=%b want=1", empty); end
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL inv_v got=%b want=0", info_ret[0].v); end
        for (int i = 0; i < 4; i++) alloc2(5'(2*i), 5'(2*i+1), 2'b11);
        for (int i = 0; i < 3; i++) wb2(2'b11, 5'(2*i), 5'(2*i+1), 32'h100 + 32'(2*i), 32'h101 + 32'(2*i));
        wb2(2'b01, 5'd6, 5'd0, 32'h106, 32'h0);
        tick();
        tick();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL inv_pending got=%b want=0", empty); end
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL inv_not_done got=%b want=0", info_ret[0].v); end
        wb2(2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        tick();
        exp = mk(1'b1, 5'd7, 32'h77);
        checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL inv_ret7 got=%h want=%h", info_ret[0], exp); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL inv_empty_end got=%b want=1", empty); end
    endtask

    task automatic test_flush;
        do_reset();
        alloc2(5'd0, 5'd1, 2'b11);
        alloc2(5'd2, 5'd3, 2'b11);
        wb2(2'b11, 5'd0, 5'd1, 32'h50, 32'h51);
        flush = 1'b1; alloc_v = 2'b11; alloc_rd[0] = 5'd4; alloc_rd[1] = 5'd5;
        wb2(2'b11, 5'd2, 5'd3, 32'h52, 32'h53);
        flush = 1'b0; alloc_v = '0;
        checks++; if (info_ret[0].v !== 1'b0) begin errors++; $display("FAIL flush_v0 got=%b want=0", info_ret[0].v); end
        checks++; if (info_ret[1].v !== 1'b0) begin errors++; $display("FAIL flush_v1 got=%b want=0", info_ret[1].v); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b want=1", empty); end
        checks++; if (alloc_robid[0] !== 5'd0) begin errors++; $display("FAIL flush_robid got=%0d want=0", alloc_robid[0]); end
        alloc_v = 2'b01; alloc_rd[0] = 5'd9; alloc_rfWrite = 2'b01;
        tick();
        alloc_v = '0;
        checks++; if (alloc_robid[0] !== 5'd1) begin errors++; $display("FAIL flush_next got=%0d want=1", alloc_robid[0]); end
        wb2(2'b01, 5'd0, 5'd0, 32'h99, 32'h0);
        tick();
        exp = mk(1'b1, 5'd9, 32'h99);
        checks++; if (info_ret[0] !== exp) begin errors++; $display("FAIL flush_ret got=%h want=%h", info_ret[0], exp); end
        checks++; if (info_ret[1].v !== 1'b0) begin errors++; $display("FAIL flush_stale got=%b want=0", info_ret[1].v); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty_end got=%b want=1", empty); end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_basic_retire();
        test_full();
        test_back_to_back();
        test_wb_invalid();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
